// File: rtl/fa9_share_ctrl.sv
// Purpose: round-robin time-multiplexer for the shared 9-bit ripple adder.
// Latency: response strobe SETTLE_CYC+1 cycles after the acceptance cycle.
// Backpressure: one-hot req_ready only in IDLE; requesters wait while SETTLE.
module fa9_share_ctrl #(
  parameter int NREQ       = 4,
  parameter int SETTLE_CYC = 3,
  parameter int IDW        = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [9*NREQ-1:0] req_a,
  input  logic [9*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic [NREQ-1:0]   req_ready,
  output logic [8:0]        add_a,
  output logic [8:0]        add_b,
  output logic              add_cin,
  input  logic [8:0]        add_sum,
  input  logic              add_cout,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [8:0]        rsp_sum,
  output logic              rsp_cout,
  output logic              busy
);

  localparam int CW = 4;

  typedef enum logic {IDLE = 1'b0, SETTLE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [8:0]       add_a_q, add_a_d;
  logic [8:0]       add_b_q, add_b_d;
  logic             add_cin_q, add_cin_d;
  logic [IDW-1:0]   pend_q, pend_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [8:0]       rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;

  logic             gnt_vld;
  logic [IDW-1:0]   gnt_id;
  logic [IDW-1:0]   cand;

  // Round-robin search: walk offsets from high to low so the nearest one to ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = IDW'((int'(ptr_q) + i) % NREQ);
      if (req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  // Next-state, operand latching, response capture and ready generation.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    pend_d      = pend_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    req_ready   = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          // Ready is suppressed while reset is held, even though state reads IDLE.
          for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == IDW'(i)) begin
              req_ready[i] = rst_n;
              add_a_d      = req_a[9*i +: 9];
              add_b_d      = req_b[9*i +: 9];
              add_cin_d    = req_cin[i];
            end
          end
          pend_d  = gnt_id;
          ptr_d   = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
          cnt_d   = CW'(1);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYC)) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = pend_q;
          rsp_sum_d   = add_sum;
          rsp_cout_d  = add_cout;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      pend_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      pend_q      <= pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign busy      = (state_q == SETTLE);

endmodule

// File: tb/tb_fa9_share_ctrl.sv
// Directed bench for fa9_share_ctrl: two instances (SETTLE_CYC 3 and 1),
// each driving an adder stub whose sum appears two cycles after its inputs.
// Expected values are hand-computed constants.
module tb_fa9_share_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_valid1, req_cin;
  logic [35:0] req_a, req_b;

  logic [3:0]  req_ready, req_ready1;
  logic [8:0]  add_a, add_b, add_a1, add_b1;
  logic        add_cin, add_cin1;
  logic [8:0]  add_sum, add_sum1;
  logic        add_cout, add_cout1;
  logic        rsp_valid, rsp_valid1;
  logic [1:0]  rsp_id, rsp_id1;
  logic [8:0]  rsp_sum, rsp_sum1;
  logic        rsp_cout, rsp_cout1;
  logic        busy, busy1;

  logic [9:0]  s1_q, s2_q, t1_q, t2_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fa9_share_ctrl #(.NREQ(4), .SETTLE_CYC(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_cin(req_cin), .req_ready(req_ready), .add_a(add_a), .add_b(add_b),
    .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy)
  );

  fa9_share_ctrl #(.NREQ(4), .SETTLE_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_a(req_a), .req_b(req_b),
    .req_cin(req_cin), .req_ready(req_ready1), .add_a(add_a1), .add_b(add_b1),
    .add_cin(add_cin1), .add_sum(add_sum1), .add_cout(add_cout1), .rsp_valid(rsp_valid1),
    .rsp_id(rsp_id1), .rsp_sum(rsp_sum1), .rsp_cout(rsp_cout1), .busy(busy1)
  );

  // Adder stubs: two-stage delay from operand change to visible sum.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0; s2_q <= '0; t1_q <= '0; t2_q <= '0;
    end else begin
      s1_q <= {1'b0, add_a} + {1'b0, add_b} + {9'b0, add_cin};
      s2_q <= s1_q;
      t1_q <= {1'b0, add_a1} + {1'b0, add_b1} + {9'b0, add_cin1};
      t2_q <= t1_q;
    end
  end
  assign add_sum   = s2_q[8:0];
  assign add_cout  = s2_q[9];
  assign add_sum1  = t2_q[8:0];
  assign add_cout1 = t2_q[9];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int r, input logic [8:0] a, input logic [8:0] b, input logic c);
    req_a[9*r +: 9] = a;
    req_b[9*r +: 9] = b;
    req_cin[r]      = c;
  endtask

  // One isolated operation on the SETTLE_CYC=3 instance, checked cycle by cycle.
  task automatic do_op(input int r, input logic [8:0] a, input logic [8:0] b, input logic c,
                       input logic [8:0] es, input logic ec, input string tag);
    set_op(r, a, b, c);
    req_valid    = 4'b0;
    req_valid[r] = 1'b1;
    #1;
    chk({tag, "_ready"}, req_ready, 32'(1) << r);
    chk({tag, "_busy0"}, busy, 0);
    step();
    req_valid = 4'b0;
    chk({tag, "_busy1"}, busy, 1);
    chk({tag, "_ready1"}, req_ready, 0);
    chk({tag, "_add_a"}, add_a, a);
    step();
    step();
    chk({tag, "_busy3"}, busy, 1);
    chk({tag, "_rsp_v3"}, rsp_valid, 0);
    step();
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_rsp_id"}, rsp_id, r);
    chk({tag, "_rsp_sum"}, rsp_sum, es);
    chk({tag, "_rsp_cout"}, rsp_cout, ec);
    chk({tag, "_busy4"}, busy, 0);
  endtask

  logic [8:0] ca [4] = '{9'd7, 9'd107, 9'd207, 9'd500};
  logic [8:0] cb [4] = '{9'd1, 9'd4, 9'd7, 9'd20};
  logic       cc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [8:0] cs [4] = '{9'd8, 9'd112, 9'd214, 9'd9};
  logic       co [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  int         fair [4] = '{0, 2, 0, 2};

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 4'hF; req_valid1 = 4'h0;
    req_a = '0; req_b = '0; req_cin = '0;
    #12;
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_cin", add_cin, 0);
    req_valid = 4'h0;
    step();
    rst_n = 1'b1;
    step();

    // Single request, then hold behaviour in IDLE.
    do_op(1, 9'd100, 9'd200, 1'b0, 9'd300, 1'b0, "single");
    step();
    chk("single_rsp_drop", rsp_valid, 0);
    chk("single_sum_hold", rsp_sum, 300);
    chk("single_add_hold", add_a, 100);

    // Modulo-512 wrap and full-scale carry-in.
    do_op(2, 9'd511, 9'd1, 1'b0, 9'd0, 1'b1, "wrap1");
    do_op(3, 9'd255, 9'd255, 1'b1, 9'd511, 1'b0, "wrap2");

    // Contention: all four requesters, grants every 4 cycles coinciding with responses.
    for (int k = 0; k < 4; k++) set_op(k, ca[k], cb[k], cc[k]);
    req_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("cont_ready%0d", k), req_ready, 32'(1) << k);
      if (k > 0) begin
        chk($sformatf("cont_rsp_v%0d", k - 1), rsp_valid, 1);
        chk($sformatf("cont_rsp_id%0d", k - 1), rsp_id, k - 1);
        chk($sformatf("cont_rsp_sum%0d", k - 1), rsp_sum, cs[k - 1]);
        chk($sformatf("cont_rsp_cout%0d", k - 1), rsp_cout, co[k - 1]);
      end
      step();
      req_valid[k] = 1'b0;
      step();
      step();
      step();
    end
    chk("cont_rsp_v3", rsp_valid, 1);
    chk("cont_rsp_id3", rsp_id, 3);
    chk("cont_rsp_sum3", rsp_sum, cs[3]);
    chk("cont_rsp_cout3", rsp_cout, co[3]);

    // Fairness: requesters 0 and 2 request continuously.
    set_op(0, 9'd1, 9'd2, 1'b0);
    set_op(2, 9'd40, 9'd50, 1'b0);
    req_valid = 4'b0101;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk($sformatf("fair_ready%0d", g), req_ready, 32'(1) << fair[g]);
      if (g > 0) chk($sformatf("fair_rsp_id%0d", g - 1), rsp_id, fair[g - 1]);
      step();
      if (g == 3) req_valid = 4'b0;
      step();
      step();
      step();
    end
    chk("fair_rsp_v_last", rsp_valid, 1);
    chk("fair_rsp_id_last", rsp_id, 2);
    chk("fair_rsp_sum_last", rsp_sum, 90);
    chk("fair_idle_ready", req_ready, 0);

    // SETTLE_CYC=1 samples before the stub has updated: stale values prove the edge.
    step();
    set_op(0, 9'd100, 9'd200, 1'b0);
    req_valid1 = 4'b0001;
    #1;
    chk("s1_ready0", req_ready1, 1);
    step();
    req_valid1 = 4'b0;
    chk("s1_busy", busy1, 1);
    step();
    chk("s1_rsp_v0", rsp_valid1, 1);
    chk("s1_rsp_id0", rsp_id1, 0);
    chk("s1_rsp_sum0_stale", rsp_sum1, 0);
    set_op(1, 9'd5, 9'd6, 1'b0);
    req_valid1 = 4'b0010;
    #1;
    chk("s1_ready1", req_ready1, 2);
    step();
    req_valid1 = 4'b0;
    step();
    chk("s1_rsp_v1", rsp_valid1, 1);
    chk("s1_rsp_id1", rsp_id1, 1);
    chk("s1_rsp_sum1_stale", rsp_sum1, 300);
    chk("s1_busy_done", busy1, 0);

    // Reset in cycle 2 of SETTLE aborts the operation and clears ptr.
    step();
    set_op(1, 9'd20, 9'd30, 1'b0);
    req_valid = 4'b0010;
    #1;
    chk("rmid_ready", req_ready, 2);
    step();
    req_valid = 4'b0;
    step();
    chk("rmid_busy_pre", busy, 1);
    rst_n = 1'b0;
    req_valid = 4'b1010;
    #1;
    chk("rmid_busy", busy, 0);
    chk("rmid_add_a", add_a, 0);
    chk("rmid_add_b", add_b, 0);
    chk("rmid_rsp_id", rsp_id, 0);
    chk("rmid_rsp_sum", rsp_sum, 0);
    chk("rmid_ready_gated", req_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rmid_no_rsp%0d", i), rsp_valid, 0);
    end
    rst_n = 1'b1;
    #1;
    chk("rpost_first_grant", req_ready, 2);
    step();
    req_valid = 4'b0;
    chk("rpost_rsp_v1", rsp_valid, 0);
    step();
    chk("rpost_rsp_v2", rsp_valid, 0);
    step();
    chk("rpost_rsp_v3", rsp_valid, 0);
    step();
    chk("rpost_rsp_valid", rsp_valid, 1);
    chk("rpost_rsp_id", rsp_id, 1);
    chk("rpost_rsp_sum", rsp_sum, 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
